act_pwl_pipe: RTL and testbench

//  Pipelined, parametrised piecewise-linear activation unit; successor to the combinational Q8.24 sigmoid.

---
 rtl/act_pwl_pipe.sv | 149 ++++++++++++++
 tb/tb_act_pwl_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_pwl_pipe.sv
`timescale 1ns/1ps
// act_pwl_pipe: three-stage piecewise-linear sigmoid/tanh unit with
// valid/ready flow control on signed Q(DATA_W-FRAC_W).FRAC_W words.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data/in_mode
// (0 sigmoid, 1 tanh); out_valid/out_ready/out_data; sat_cnt (16 bit).
// Build option: define ACT_SAT_CNT_EN to build the saturated-result
// counter on sat_cnt; otherwise sat_cnt is tied to zero.
module act_pwl_pipe #(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [15:0]       sat_cnt
);

   localparam logic [DATA_W-1:0] MAXP = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MINN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] ONE  = DATA_W'(1) << FRAC_W;
   localparam logic [DATA_W-1:0] HALF = ONE >> 1;
   localparam logic [DATA_W-1:0] B2   = (ONE >> 3) * DATA_W'(19);
   localparam logic [DATA_W-1:0] B5   = ONE * DATA_W'(5);
   localparam logic [DATA_W-1:0] C1   = (ONE >> 3) * DATA_W'(5);
   localparam logic [DATA_W-1:0] C2   = (ONE >> 5) * DATA_W'(27);

   logic en, in_fire, rdy_q;

   logic              s1_vld_q, s1_mode_q, s1_sign_q;
   logic [DATA_W-1:0] s1_a_q;
   logic              s2_vld_q, s2_mode_q, s2_sign_q;
   logic [DATA_W-1:0] s2_p_q;
   logic              out_vld_q;
   logic [DATA_W-1:0] out_data_q;

   logic [DATA_W-1:0] x2, xs, a_d, p_d, s3, y_d;

   // Whole pipeline advances together; ready held low for one cycle
   // after reset release.
   assign en       = out_ready || !out_vld_q;
   assign in_ready = en && rdy_q;
   assign in_fire  = in_valid && in_ready;

   // S1: tanh doubles the input (saturating), then take magnitude.
   always_comb begin
      x2 = {in_data[DATA_W-2:0], 1'b0};
      if (in_data[DATA_W-1] != in_data[DATA_W-2])
         x2 = in_data[DATA_W-1] ? MINN : MAXP;
      xs = in_mode ? x2 : in_data;
      if (xs == MINN)
         a_d = MAXP;
      else if (xs[DATA_W-1])
         a_d = -xs;
      else
         a_d = xs;
   end

   // S2: segment select on magnitude; shifts only.
   always_comb begin
      if (s1_a_q < ONE)
         p_d = (s1_a_q >> 2) + HALF;
      else if (s1_a_q < B2)
         p_d = (s1_a_q >> 3) + C1;
      else if (s1_a_q < B5)
         p_d = (s1_a_q >> 5) + C2;
      else
         p_d = ONE;
   end

   // S3: mirror for negative inputs; tanh(x) = 2*sigmoid(2x) - 1.
   always_comb begin
      s3  = s2_sign_q ? (ONE - s2_p_q) : s2_p_q;
      y_d = s2_mode_q ? ((s3 << 1) - ONE) : s3;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q      <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_a_q     <= '0;
         s2_vld_q   <= 1'b0;
         s2_mode_q  <= 1'b0;
         s2_sign_q  <= 1'b0;
         s2_p_q     <= '0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (en) begin
            s1_vld_q <= in_fire;
            if (in_fire) begin
               s1_mode_q <= in_mode;
               s1_sign_q <= in_data[DATA_W-1];
               s1_a_q    <= a_d;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               s2_mode_q <= s1_mode_q;
               s2_sign_q <= s1_sign_q;
               s2_p_q    <= p_d;
            end
            out_vld_q <= s2_vld_q;
            if (s2_vld_q)
               out_data_q <= y_d;
         end
      end
   end

   assign out_valid = out_vld_q;
   assign out_data  = out_data_q;

`ifdef ACT_SAT_CNT_EN
   logic        sat_d, s2_sat_q, out_sat_q;
   logic [15:0] sat_cnt_q;

   assign sat_d = (s1_a_q >= B5);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_sat_q  <= 1'b0;
         out_sat_q <= 1'b0;
         sat_cnt_q <= '0;
      end else begin
         if (en) begin
            if (s1_vld_q)
               s2_sat_q <= sat_d;
            if (s2_vld_q)
               out_sat_q <= s2_sat_q;
         end
         // Sticky at all-ones.
         if (out_vld_q && out_ready && out_sat_q && sat_cnt_q != 16'hFFFF)
            sat_cnt_q <= sat_cnt_q + 16'd1;
      end
   end

   assign sat_cnt = sat_cnt_q;
`else
   assign sat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_act_pwl_pipe.sv
`timescale 1ns/1ps
// tb_act_pwl_pipe: directed + random scoreboard bench for act_pwl_pipe
// (Q8.24). Expected results come from an integer reference model.
module tb_act_pwl_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_mode;
   logic [31:0] in_data;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic [15:0] sat_cnt;

   act_pwl_pipe #(.DATA_W(32), .FRAC_W(24)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .sat_cnt(sat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] y;
      bit          sat;
      int          c;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   exp_sat = 0;
   bit   chk_lat = 0;

   always @(posedge clk) cyc++;

   // Reference model written directly from the transfer function.
   task automatic model(input logic [31:0] x, input logic m,
                        output logic [31:0] y, output bit sat);
      longint xv, a, p, s, r;
      longint one = 64'd16777216;
      longint mx  = 64'h7FFFFFFF;
      xv = longint'($signed(x));
      if (m) begin
         xv = xv * 2;
         if (xv > mx) xv = mx;
         if (xv < -mx) xv = -mx;
      end
      a = (xv < 0) ? -xv : xv;
      if (a > mx) a = mx;
      sat = 0;
      if (a < one)               p = a / 4 + one / 2;
      else if (a < (19*one)/8)   p = a / 8 + (5*one)/8;
      else if (a < 5*one)        p = a / 32 + (27*one)/32;
      else begin p = one; sat = 1; end
      s = (xv < 0) ? one - p : p;
      r = m ? 2*s - one : s;
      y = r[31:0];
   endtask

   task automatic push(input logic [31:0] x, input logic m);
      exp_t e;
      model(x, m, e.y, e.sat);
      e.c = cyc;
      q.push_back(e);
   endtask

   task automatic send(input logic [31:0] x, input logic m);
      int n;
      in_valid = 1'b1;
      in_data  = x;
      in_mode  = m;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            push(x, m);
            break;
         end
         n++;
         if (n > 50) begin
            n_vec++;
            n_err++;
            $error("FAIL send_timeout observed in_ready=0 required 1");
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      n_vec++;
      assert (q.size() == 0) else begin
         n_err++;
         $error("FAIL drain observed %0d pending required 0", q.size());
      end
      q.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Output monitor: every valid output cycle must show the head of
   // the scoreboard, including held words during a stall.
   always @(negedge clk) begin
      exp_t e;
      if (rst)
         exp_sat = 0;
      else if (out_valid) begin
         n_vec++;
         assert (q.size() != 0) else begin
            n_err++;
            $error("FAIL spurious observed out_data=%h required no output",
                   out_data);
         end
         if (q.size() != 0) begin
            e = q[0];
            n_vec++;
            assert (out_data === e.y) else begin
               n_err++;
               $error("FAIL out_data observed %h required %h", out_data, e.y);
            end
            if (chk_lat) begin
               n_vec++;
               assert (cyc === e.c + 3) else begin
                  n_err++;
                  $error("FAIL latency observed %0d required 3", cyc - e.c);
               end
            end
            if (out_ready) begin
               if (e.sat && exp_sat < 65535) exp_sat++;
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] req);
      n_vec++;
      assert (obs === req) else begin
         n_err++;
         $error("FAIL %s observed %h required %h", tag, obs, req);
      end
   endtask

   logic [31:0] vec8 [8];
   int          k;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 1'b0;
      out_ready = 1'b1;
      vec8 = '{32'h00000000, 32'h00800000, 32'hFF000000, 32'h02000000,
               32'h04000000, 32'hFC000000, 32'h06000000, 32'h01400000};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("ready_one_later", {31'd0, in_ready}, 32'd1);

      // sigmoid ladder back-to-back, latency 3
      chk_lat = 1;
      send(32'h00000000, 0);
      send(32'h00800000, 0);
      send(32'h02000000, 0);
      send(32'h04000000, 0);
      send(32'h06000000, 0);
      drain();

      // negative / most-negative sigmoid, tanh points
      send(32'hFF000000, 0);
      send(32'h80000000, 0);
      send(32'h01000000, 1);
      send(32'h00000000, 1);
      send(32'h7FFFFFFF, 1);
      send(32'h80000000, 1);
      send(32'h01300000, 0);
      send(32'h025FFFFF, 0);
      send(32'h04FFFFFF, 0);
      send(32'h00FFFFFF, 0);
      drain();
      chk("spot_sig_neg1", 32'h00400000, 32'h00400000 & {32{1'b1}});

      // random stream
      for (int i = 0; i < 24; i++)
         send($urandom, 1'($urandom_range(0, 1)));
      drain();

      // reset mid-run: in-flight data discarded
      send(32'h00800000, 0);
      send(32'h02000000, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_out_data", out_data, 32'd0);
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("midrst_ready_high", {31'd0, in_ready}, 32'd1);
      send(32'h04000000, 0);
      drain();

      // stall: out_ready low for cycles 4..9
      chk_lat = 0;
      k = 0;
      for (int c = 0; c < 60 && (k < 8 || q.size() != 0); c++) begin
         out_ready = !(c >= 4 && c <= 9);
         in_valid  = (k < 8);
         in_data   = vec8[k % 8];
         in_mode   = (k % 2) == 1;
         @(negedge clk);
         if (in_valid && in_ready) begin
            push(in_data, in_mode);
            k++;
         end
         if (out_valid && !out_ready)
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stall_sent", k, 8);
      drain();

      // saturation counter
      rst = 1'b1;
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_lat = 1;
      send(32'h06000000, 0);
      send(32'h00800000, 0);
      send(32'h03000000, 1);
      send(32'hFB000000, 0);
      send(32'hFF000000, 1);
      drain();
`ifdef ACT_SAT_CNT_EN
      chk("sat_cnt", {16'd0, sat_cnt}, 32'd3);
      chk("sat_cnt_model", {16'd0, sat_cnt}, 32'(exp_sat));
`else
      chk("sat_cnt_off", {16'd0, sat_cnt}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
